// File: rtl/pong_engine.sv
// 1-D Pong game core: serve/rally/point/game-over sequencing for an LED strip.
// Takes the aclk/bclk tick sources and the two player buttons; produces a registered LED frame, the scores and the status.
module pong_engine #(
    parameter int NUM_LEDS    = 16,
    parameter int POS_W       = 4,
    parameter int ZONE        = 3,
    parameter int WIN_SCORE   = 5,
    parameter int SCORE_W     = 3,
    parameter int PAUSE_TICKS = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                go,
    input  logic                aclk,
    input  logic                bclk,
    input  logic                btn_l,
    input  logic                btn_r,
    output logic [NUM_LEDS-1:0] led_frame,
    output logic [POS_W-1:0]    ball_pos,
    output logic [SCORE_W-1:0]  score_l,
    output logic [SCORE_W-1:0]  score_r,
    output logic                game_over,
    output logic                winner,
    output logic [2:0]          state
);
    // state  | meaning
    // IDLE   | game disabled, strip dark
    // SERVE  | ball parked at the server's end, waiting for the server's hit
    // MOVE   | rally in progress
    // POINT  | point scored, strip flashes with aclk for PAUSE_TICKS ticks
    // OVER   | match won, winner's half lit until go drops
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SERVE = 3'd1,
        S_MOVE  = 3'd2,
        S_POINT = 3'd3,
        S_OVER  = 3'd4
    } state_t;

    localparam int PAUSE_W = $clog2(PAUSE_TICKS + 1);
    localparam logic [POS_W-1:0]    LAST    = POS_W'(NUM_LEDS - 1);
    localparam logic [POS_W-1:0]    ZONE_HI = POS_W'(NUM_LEDS - ZONE);
    localparam logic [POS_W-1:0]    ZONE_LO = POS_W'(ZONE - 1);
    localparam logic [SCORE_W-1:0]  WIN     = SCORE_W'(WIN_SCORE);
    localparam logic [NUM_LEDS-1:0] LOW_HALF =
        {{(NUM_LEDS - NUM_LEDS/2){1'b0}}, {(NUM_LEDS/2){1'b1}}};

    state_t               state_q, state_d;
    logic [POS_W-1:0]     pos_q, pos_d;
    logic                 dir_q, dir_d;
    logic                 server_q, server_d;
    logic                 scorer_q, scorer_d;
    logic [PAUSE_W-1:0]   pause_q, pause_d;
    logic [SCORE_W-1:0]   score_l_q, score_l_d, score_r_q, score_r_d;
    logic                 game_over_q, game_over_d, winner_q, winner_d;
    logic [NUM_LEDS-1:0]  led_q, led_d;
    logic                 aclk_q, bclk_q;
    logic [2:0]           btn_l_q, btn_r_q;

    logic a_tick, b_tick, hit_l, hit_r, rx_hit, in_zone, award, award_side;

    always_comb begin
        a_tick = aclk & ~aclk_q;
        b_tick = bclk & ~bclk_q;
        hit_l  = btn_l_q[1] & ~btn_l_q[2];
        hit_r  = btn_r_q[1] & ~btn_r_q[2];
        rx_hit  = dir_q ? hit_r : hit_l;
        in_zone = dir_q ? (pos_q >= ZONE_HI) : (pos_q <= ZONE_LO);
        award      = 1'b0;
        award_side = 1'b0;

        state_d     = state_q;
        pos_d       = pos_q;
        dir_d       = dir_q;
        server_d    = server_q;
        scorer_d    = scorer_q;
        pause_d     = pause_q;
        score_l_d   = score_l_q;
        score_r_d   = score_r_q;
        game_over_d = game_over_q;
        winner_d    = winner_q;

        if (!go) begin
            state_d     = S_IDLE;
            pos_d       = '0;
            dir_d       = 1'b0;
            server_d    = 1'b0;
            score_l_d   = '0;
            score_r_d   = '0;
            game_over_d = 1'b0;
            winner_d    = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_d = S_SERVE;
                    pos_d   = server_q ? LAST : '0;
                end
                S_SERVE: begin
                    if (server_q ? hit_r : hit_l) begin
                        state_d = S_MOVE;
                        dir_d   = ~server_q;
                    end
                end
                S_MOVE: begin
                    // The sender is the side the ball travels away from.
                    award_side = ~dir_q;
                    if (rx_hit && in_zone) begin
                        dir_d = ~dir_q;
                    end else if (rx_hit) begin
                        award = 1'b1;
                    end else if (b_tick) begin
                        if ((dir_q && pos_q == LAST) || (!dir_q && pos_q == '0))
                            award = 1'b1;
                        else
                            pos_d = dir_q ? pos_q + POS_W'(1) : pos_q - POS_W'(1);
                    end
                end
                S_POINT: begin
                    if (a_tick) begin
                        if (pause_q == PAUSE_W'(1)) begin
                            if ((scorer_q ? score_r_q : score_l_q) == WIN) begin
                                state_d     = S_OVER;
                                game_over_d = 1'b1;
                                winner_d    = scorer_q;
                            end else begin
                                state_d  = S_SERVE;
                                server_d = ~scorer_q;
                                pos_d    = scorer_q ? '0 : LAST;
                            end
                        end else begin
                            pause_d = pause_q - PAUSE_W'(1);
                        end
                    end
                end
                default: ;
            endcase

            if (award) begin
                state_d  = S_POINT;
                scorer_d = award_side;
                pause_d  = PAUSE_W'(PAUSE_TICKS);
                if (award_side)
                    score_r_d = (score_r_q == WIN) ? WIN : score_r_q + SCORE_W'(1);
                else
                    score_l_d = (score_l_q == WIN) ? WIN : score_l_q + SCORE_W'(1);
            end
        end

        led_d = '0;
        case (state_d)
            S_SERVE, S_MOVE: led_d[pos_d] = 1'b1;
            S_POINT:         led_d = aclk ? '1 : '0;
            S_OVER:          led_d = winner_d ? ~LOW_HALF : LOW_HALF;
            default:         led_d = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            pos_q       <= '0;
            dir_q       <= 1'b0;
            server_q    <= 1'b0;
            scorer_q    <= 1'b0;
            pause_q     <= '0;
            score_l_q   <= '0;
            score_r_q   <= '0;
            game_over_q <= 1'b0;
            winner_q    <= 1'b0;
            led_q       <= '0;
            aclk_q      <= 1'b0;
            bclk_q      <= 1'b0;
            btn_l_q     <= '0;
            btn_r_q     <= '0;
        end else begin
            state_q     <= state_d;
            pos_q       <= pos_d;
            dir_q       <= dir_d;
            server_q    <= server_d;
            scorer_q    <= scorer_d;
            pause_q     <= pause_d;
            score_l_q   <= score_l_d;
            score_r_q   <= score_r_d;
            game_over_q <= game_over_d;
            winner_q    <= winner_d;
            led_q       <= led_d;
            aclk_q      <= aclk;
            bclk_q      <= bclk;
            // Bits [1:0] synchronize the async button, bit 2 holds the previous value for edge detect.
            btn_l_q     <= {btn_l_q[1:0], btn_l};
            btn_r_q     <= {btn_r_q[1:0], btn_r};
        end
    end

    assign led_frame = led_q;
    assign ball_pos  = pos_q;
    assign score_l   = score_l_q;
    assign score_r   = score_r_q;
    assign game_over = game_over_q;
    assign winner    = winner_q;
    assign state     = state_q;
endmodule

// File: tb/tb_pong_engine.sv
// Self-checking bench for pong_engine: a table of game actions with expected outputs,
// expectations queued as each action is driven and compared once the DUT has responded.
module tb_pong_engine;
    logic        clk = 1'b0;
    logic        reset, go, aclk, bclk, btn_l, btn_r;
    logic [15:0] led_frame;
    logic [3:0]  ball_pos;
    logic [2:0]  score_l, score_r, state;
    logic        game_over, winner;

    pong_engine dut (
        .clk(clk), .reset(reset), .go(go), .aclk(aclk), .bclk(bclk),
        .btn_l(btn_l), .btn_r(btn_r), .led_frame(led_frame), .ball_pos(ball_pos),
        .score_l(score_l), .score_r(score_r), .game_over(game_over),
        .winner(winner), .state(state)
    );

    always #5 clk = ~clk;

    typedef enum {OP_GO1, OP_GO0, OP_RST, OP_PL, OP_PR, OP_PRBT, OP_BT, OP_AT, OP_AHI, OP_ALO} op_t;
    typedef struct {
        logic [2:0]  st;
        logic [3:0]  pos;
        logic [2:0]  sl;
        logic [2:0]  sr;
        logic        gov;
        logic        win;
        logic [15:0] led;
    } exp_t;
    typedef struct {
        op_t  op;
        exp_t e;
    } vec_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;

    function automatic void add(op_t op, int st, int pos, int sl, int sr, int gov, int win);
        vec_t v;
        v.op    = op;
        v.e.st  = 3'(st);
        v.e.pos = 4'(pos);
        v.e.sl  = 3'(sl);
        v.e.sr  = 3'(sr);
        v.e.gov = 1'(gov);
        v.e.win = 1'(win);
        if (st == 1 || st == 2)    v.e.led = 16'h0001 << pos;
        else if (st == 4)          v.e.led = (win != 0) ? 16'hFF00 : 16'h00FF;
        else if (op == OP_AHI)     v.e.led = 16'hFFFF;
        else                       v.e.led = 16'h0000;
        vecs.push_back(v);
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic compare(string tag);
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL %s: scoreboard empty, got %0h, expected an entry", tag, state);
            return;
        end
        e = sb.pop_front();
        chk({tag, ".state"},     32'(state),     32'(e.st));
        chk({tag, ".ball_pos"},  32'(ball_pos),  32'(e.pos));
        chk({tag, ".score_l"},   32'(score_l),   32'(e.sl));
        chk({tag, ".score_r"},   32'(score_r),   32'(e.sr));
        chk({tag, ".game_over"}, 32'(game_over), 32'(e.gov));
        chk({tag, ".winner"},    32'(winner),    32'(e.win));
        chk({tag, ".led_frame"}, 32'(led_frame), 32'(e.led));
    endtask

    task automatic clk1();
        @(negedge clk);
    endtask

    task automatic apply(op_t op);
        case (op)
            OP_GO1:  begin go = 1'b1; clk1(); end
            OP_GO0:  begin go = 1'b0; clk1(); end
            OP_RST:  begin reset = 1'b1; clk1(); reset = 1'b0; end
            OP_PL:   begin btn_l = 1'b1; repeat (3) clk1(); btn_l = 1'b0; clk1(); end
            OP_PR:   begin btn_r = 1'b1; repeat (3) clk1(); btn_r = 1'b0; clk1(); end
            OP_PRBT: begin
                btn_r = 1'b1; repeat (2) clk1();
                bclk = 1'b1; clk1();
                bclk = 1'b0; btn_r = 1'b0; clk1();
            end
            OP_BT:   begin bclk = 1'b1; clk1(); bclk = 1'b0; clk1(); end
            OP_AT:   begin aclk = 1'b1; clk1(); aclk = 1'b0; clk1(); end
            OP_AHI:  begin aclk = 1'b1; clk1(); end
            OP_ALO:  begin aclk = 1'b0; clk1(); end
            default: ;
        endcase
    endtask

    initial begin
        exp_t e;
        int sr;

        // Reset test mid-rally, then a full match.
        add(OP_GO1, 1, 0, 0, 0, 0, 0);
        add(OP_PL, 2, 0, 0, 0, 0, 0);
        for (int i = 1; i <= 7; i++) add(OP_BT, 2, i, 0, 0, 0, 0);
        add(OP_RST, 0, 0, 0, 0, 0, 0);
        add(OP_GO1, 1, 0, 0, 0, 0, 0);
        add(OP_PL, 2, 0, 0, 0, 0, 0);
        for (int i = 1; i <= 15; i++) add(OP_BT, 2, i, 0, 0, 0, 0);
        add(OP_BT, 3, 15, 1, 0, 0, 0);
        add(OP_AHI, 3, 15, 1, 0, 0, 0);
        add(OP_ALO, 3, 15, 1, 0, 0, 0);
        for (int i = 0; i < 2; i++) add(OP_AT, 3, 15, 1, 0, 0, 0);
        add(OP_AT, 1, 15, 1, 0, 0, 0);
        add(OP_PR, 2, 15, 1, 0, 0, 0);
        add(OP_BT, 2, 14, 1, 0, 0, 0);
        add(OP_PL, 3, 14, 1, 1, 0, 0);
        for (int i = 0; i < 3; i++) add(OP_AT, 3, 14, 1, 1, 0, 0);
        add(OP_AT, 1, 0, 1, 1, 0, 0);
        add(OP_PL, 2, 0, 1, 1, 0, 0);
        for (int i = 1; i <= 8; i++) add(OP_BT, 2, i, 1, 1, 0, 0);
        add(OP_PR, 3, 8, 2, 1, 0, 0);
        for (int i = 0; i < 3; i++) add(OP_AT, 3, 8, 2, 1, 0, 0);
        add(OP_AT, 1, 15, 2, 1, 0, 0);
        add(OP_PR, 2, 15, 2, 1, 0, 0);
        for (int i = 1; i <= 13; i++) add(OP_BT, 2, 15 - i, 2, 1, 0, 0);
        add(OP_PL, 2, 2, 2, 1, 0, 0);
        for (int i = 1; i <= 12; i++) add(OP_BT, 2, 2 + i, 2, 1, 0, 0);
        add(OP_PRBT, 2, 14, 2, 1, 0, 0);
        add(OP_BT, 2, 13, 2, 1, 0, 0);
        for (int i = 1; i <= 13; i++) add(OP_BT, 2, 13 - i, 2, 1, 0, 0);
        add(OP_BT, 3, 0, 2, 2, 0, 0);
        for (int i = 0; i < 3; i++) add(OP_AT, 3, 0, 2, 2, 0, 0);
        add(OP_AT, 1, 0, 2, 2, 0, 0);
        for (sr = 3; sr <= 5; sr++) begin
            add(OP_PL, 2, 0, 2, sr - 1, 0, 0);
            for (int i = 1; i <= 13; i++) add(OP_BT, 2, i, 2, sr - 1, 0, 0);
            add(OP_PR, 2, 13, 2, sr - 1, 0, 0);
            for (int i = 1; i <= 13; i++) add(OP_BT, 2, 13 - i, 2, sr - 1, 0, 0);
            add(OP_BT, 3, 0, 2, sr, 0, 0);
            for (int i = 0; i < 3; i++) add(OP_AT, 3, 0, 2, sr, 0, 0);
            if (sr == 5) add(OP_AT, 4, 0, 2, 5, 1, 1);
            else         add(OP_AT, 1, 0, 2, sr, 0, 0);
        end

        reset = 1'b1; go = 1'b0; aclk = 1'b0; bclk = 1'b0; btn_l = 1'b0; btn_r = 1'b0;
        repeat (3) clk1();
        e = '{st: 3'd0, pos: 4'd0, sl: 3'd0, sr: 3'd0, gov: 1'b0, win: 1'b0, led: 16'h0000};
        sb.push_back(e);
        compare("reset");
        reset = 1'b0;
        clk1();

        for (int k = 0; k < vecs.size(); k++) begin
            sb.push_back(vecs[k].e);
            apply(vecs[k].op);
            compare($sformatf("vec%0d", k));
        end

        // Held right button during OVER, then go low clears the match.
        btn_r = 1'b1;
        for (int i = 0; i < 20; i++) begin
            e = '{st: 3'd4, pos: 4'd0, sl: 3'd2, sr: 3'd5, gov: 1'b1, win: 1'b1, led: 16'hFF00};
            sb.push_back(e);
            apply(OP_BT);
            compare($sformatf("over_hold%0d", i));
        end
        e = '{st: 3'd0, pos: 4'd0, sl: 3'd0, sr: 3'd0, gov: 1'b0, win: 1'b0, led: 16'h0000};
        sb.push_back(e);
        apply(OP_GO0);
        compare("go_low");
        btn_r = 1'b0;
        e = '{st: 3'd0, pos: 4'd0, sl: 3'd0, sr: 3'd0, gov: 1'b0, win: 1'b0, led: 16'h0000};
        sb.push_back(e);
        apply(OP_BT);
        compare("idle_hold");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
